// File: rtl/bingo_draw_unit.sv
// BinGo draw engine: picks balls 1..MAX_NUM without replacement from an external PRNG,
// resampling rejected values and falling back to a linear bitmap scan after MAX_TRIES misses.
module bingo_draw_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NUM    = 75,
  parameter int MAX_TRIES  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  new_game,
  input  logic                  draw_req,
  input  logic [DATA_WIDTH-1:0] rnd_in,
  output logic                  rnd_en,
  output logic                  draw_valid,
  output logic [6:0]            draw_num,
  output logic [6:0]            draw_count,
  output logic                  busy,
  output logic                  all_drawn,
  output logic                  draw_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CHECK  = 2'd2,
    SCAN   = 2'd3
  } state_t;

  localparam logic [6:0] MAX_BALL  = 7'(MAX_NUM);
  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  state_t             state_r, state_s;
  logic [MAX_NUM-1:0] bitmap_r, bitmap_s;
  logic [7:0]         tries_r, tries_s, tries_inc_s;
  logic [6:0]         scan_idx_r, scan_idx_s;
  logic [6:0]         draw_num_r, draw_num_s;
  logic [6:0]         draw_count_r, draw_count_s;
  logic               draw_valid_r, draw_valid_s;
  logic               draw_err_r, draw_err_s;
  logic [6:0]         cand_s;
  logic               cand_ok_s;
  logic [127:0]       drawn_ext_s;

  // Returns the bitmap with the bit for the given ball (1-based) set.
  function automatic logic [MAX_NUM-1:0] mark_ball(input logic [MAX_NUM-1:0] bm,
                                                   input logic [6:0] ball);
    logic [MAX_NUM-1:0] res;
    res = bm;
    res[ball - 7'd1] = 1'b1;
    return res;
  endfunction

  // Only the low seven PRNG bits form a candidate; the rest are deliberately dropped.
  generate
    if (DATA_WIDTH > 7) begin : g_unused_rnd
      logic unused_rnd_s;
      assign unused_rnd_s = ^rnd_in[DATA_WIDTH-1:7];
    end
  endgenerate

  // Zero-extended bitmap lets any 7-bit index be looked up safely.
  assign drawn_ext_s = 128'(bitmap_r);
  assign cand_s      = rnd_in[6:0];
  assign cand_ok_s   = (cand_s != 7'd0) && (cand_s <= MAX_BALL) && !drawn_ext_s[cand_s - 7'd1];
  assign tries_inc_s = tries_r + 8'd1;

  assign rnd_en     = (state_r == SAMPLE);
  assign busy       = (state_r != IDLE);
  assign all_drawn  = (draw_count_r == MAX_BALL);
  assign draw_valid = draw_valid_r;
  assign draw_num   = draw_num_r;
  assign draw_count = draw_count_r;
  assign draw_err   = draw_err_r;

  // Next-state and datapath update; new_game overrides every state.
  always_comb begin
    state_s      = state_r;
    bitmap_s     = bitmap_r;
    tries_s      = tries_r;
    scan_idx_s   = scan_idx_r;
    draw_num_s   = draw_num_r;
    draw_count_s = draw_count_r;
    draw_valid_s = 1'b0;
    draw_err_s   = 1'b0;
    if (new_game) begin
      state_s      = IDLE;
      bitmap_s     = '0;
      tries_s      = 8'd0;
      scan_idx_s   = 7'd0;
      draw_num_s   = 7'd0;
      draw_count_s = 7'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (draw_req && !all_drawn) begin
            tries_s = 8'd0;
            state_s = SAMPLE;
          end else if (draw_req) begin
            draw_err_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        SAMPLE: state_s = CHECK;
        CHECK: begin
          if (cand_ok_s) begin
            bitmap_s     = mark_ball(bitmap_r, cand_s);
            draw_num_s   = cand_s;
            draw_count_s = draw_count_r + 7'd1;
            draw_valid_s = 1'b1;
            state_s      = IDLE;
          end else if (tries_inc_s == TRY_LIMIT) begin
            tries_s    = tries_inc_s;
            scan_idx_s = 7'd0;
            state_s    = SCAN;
          end else begin
            tries_s = tries_inc_s;
            state_s = SAMPLE;
          end
        end
        SCAN: begin
          // Termination is guaranteed: entry required at least one clear bit.
          if (!drawn_ext_s[scan_idx_r]) begin
            bitmap_s     = mark_ball(bitmap_r, scan_idx_r + 7'd1);
            draw_num_s   = scan_idx_r + 7'd1;
            draw_count_s = draw_count_r + 7'd1;
            draw_valid_s = 1'b1;
            state_s      = IDLE;
          end else begin
            scan_idx_s = scan_idx_r + 7'd1;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      bitmap_r     <= '0;
      tries_r      <= 8'd0;
      scan_idx_r   <= 7'd0;
      draw_num_r   <= 7'd0;
      draw_count_r <= 7'd0;
      draw_valid_r <= 1'b0;
      draw_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      bitmap_r     <= bitmap_s;
      tries_r      <= tries_s;
      scan_idx_r   <= scan_idx_s;
      draw_num_r   <= draw_num_s;
      draw_count_r <= draw_count_s;
      draw_valid_r <= draw_valid_s;
      draw_err_r   <= draw_err_s;
    end
  end

endmodule

// File: tb/tb_bingo_draw_unit.sv
// Directed bench for bingo_draw_unit: a draw table plus hand sequences for abort,
// exhaustion and asynchronous reset in the middle of a scan.
module tb_bingo_draw_unit;

  logic       clk;
  logic       rstn;
  logic       new_game;
  logic       draw_req;
  logic [7:0] rnd_in;
  logic       rnd_en;
  logic       draw_valid;
  logic [6:0] draw_num;
  logic [6:0] draw_count;
  logic       busy;
  logic       all_drawn;
  logic       draw_err;

  int n_checks = 0;
  int n_fail   = 0;

  bingo_draw_unit #(.DATA_WIDTH(8), .MAX_NUM(75), .MAX_TRIES(16)) dut (
    .clk(clk), .rstn(rstn), .new_game(new_game), .draw_req(draw_req),
    .rnd_in(rnd_in), .rnd_en(rnd_en), .draw_valid(draw_valid),
    .draw_num(draw_num), .draw_count(draw_count), .busy(busy),
    .all_drawn(all_drawn), .draw_err(draw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v0;
    logic [7:0] v1;
    logic [7:0] v2;
    int         nv;
    int         num;
    int         edges;
    int         count;
    int         pulses;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Requests one ball; the bench plays the PRNG, presenting the next value on each rnd_en.
  task automatic run_draw(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                          input int nv, output int edges, output int pulses,
                          output int num, output int busy0, output int busy_end);
    logic [7:0] vals[3];
    int  k;
    bit  done;
    vals   = '{v0, v1, v2};
    k      = 0;
    edges  = 0;
    pulses = 0;
    done   = 1'b0;
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    #1 draw_req = 1'b0;
    busy0 = int'(busy);
    while (!done && edges < 400) begin
      @(negedge clk);
      if (rnd_en) begin
        pulses++;
        rnd_in = vals[(k < nv) ? k : nv - 1];
        k++;
      end
      @(posedge clk);
      edges++;
      #1;
      if (draw_valid) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL draw_timeout: got no draw_valid expected one within 400 edges");
    end
    num      = int'(draw_num);
    busy_end = int'(busy);
  endtask

  initial begin
    int edges, pulses, num, b0, b1;

    tbl[0] = '{8'h2A, 8'h00, 8'h00, 1, 42,  2, 1,  1};
    tbl[1] = '{8'h2A, 8'h05, 8'h00, 2,  5,  4, 2,  2};
    tbl[2] = '{8'h00, 8'h4C, 8'hCB, 3, 75,  6, 3,  3};
    tbl[3] = '{8'h01, 8'h00, 8'h00, 1,  1,  2, 4,  1};
    tbl[4] = '{8'h82, 8'h00, 8'h00, 1,  2,  2, 5,  1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1,  3, 35, 6, 16};
    tbl[6] = '{8'h05, 8'h2A, 8'h04, 3,  4,  6, 7,  3};
    tbl[7] = '{8'h7F, 8'h00, 8'h00, 1,  6, 38, 8, 16};

    rstn     = 1'b0;
    new_game = 1'b0;
    draw_req = 1'b0;
    rnd_in   = 8'h00;
    #12;
    check("reset_rnd_en", int'(rnd_en), 0);
    check("reset_valid", int'(draw_valid), 0);
    check("reset_num", int'(draw_num), 0);
    check("reset_count", int'(draw_count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_all_drawn", int'(all_drawn), 0);
    check("reset_err", int'(draw_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_draw(tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].nv, edges, pulses, num, b0, b1);
      check($sformatf("vec%0d_num", i), num, tbl[i].num);
      check($sformatf("vec%0d_edges", i), edges, tbl[i].edges);
      check($sformatf("vec%0d_count", i), int'(draw_count), tbl[i].count);
      check($sformatf("vec%0d_pulses", i), pulses, tbl[i].pulses);
      check($sformatf("vec%0d_busy_start", i), b0, 1);
      check($sformatf("vec%0d_busy_end", i), b1, 0);
    end

    // new_game during CHECK aborts the draw
    @(negedge clk);
    rnd_in   = 8'h10;
    draw_req = 1'b1;
    @(posedge clk);
    #1 draw_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    check("abort_valid", int'(draw_valid), 0);
    check("abort_count", int'(draw_count), 0);
    check("abort_num", int'(draw_num), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check("abort_valid_late", int'(draw_valid), 0);
    check("abort_busy_late", int'(busy), 0);

    // exhaustion: draw every ball in order
    for (int i = 1; i <= 75; i++) begin
      if (i == 75) check("pre_all_drawn", int'(all_drawn), 0);
      run_draw(8'(i), 8'h00, 8'h00, 1, edges, pulses, num, b0, b1);
      check($sformatf("exh_num%0d", i), num, i);
    end
    check("exh_count", int'(draw_count), 75);
    check("exh_all_drawn", int'(all_drawn), 1);
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    #1 draw_req = 1'b0;
    check("exh_err", int'(draw_err), 1);
    check("exh_busy", int'(busy), 0);
    check("exh_rnd_en", int'(rnd_en), 0);
    @(posedge clk);
    #1;
    check("exh_err_clear", int'(draw_err), 0);
    check("exh_busy_late", int'(busy), 0);

    // asynchronous reset while scanning
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      run_draw(8'(i), 8'h00, 8'h00, 1, edges, pulses, num, b0, b1);
      check($sformatf("prescan_num%0d", i), num, i);
    end
    @(negedge clk);
    rnd_in   = 8'h00;
    draw_req = 1'b1;
    @(posedge clk);
    #1 draw_req = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("scan_busy", int'(busy), 1);
    check("scan_rnd_en", int'(rnd_en), 0);
    check("scan_count", int'(draw_count), 3);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(draw_count), 0);
    check("arst_num", int'(draw_num), 0);
    check("arst_valid", int'(draw_valid), 0);
    check("arst_rnd_en", int'(rnd_en), 0);
    check("arst_all_drawn", int'(all_drawn), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
